// File: rtl/onehot_decoder_sync.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder_sync
// Description : Registered binary-to-one-hot decoder behind a 2-entry FIFO
//               with valid/ready handshakes on both sides. Defining
//               DEC_COUNT_EN adds the xfer_count completed-transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder_sync #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 16,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot
`ifdef DEC_COUNT_EN
    ,
    output logic [CNT_W-1:0] xfer_count
`endif
);

    localparam logic [1:0] c_FULL = 2'd2;

    logic [OUT_W-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_out_valid;

    logic             w_push;
    logic             w_pop;
    logic [OUT_W-1:0] w_word;
    logic [1:0]       w_count_nxt;

    // in_ready depends only on stored occupancy, so a pop while full
    // cannot open the input in the same cycle.
    assign in_ready   = (r_count != c_FULL);
    assign out_valid  = r_out_valid;
    assign w_push     = in_valid & in_ready;
    assign w_pop      = r_out_valid & out_ready;
    assign w_word     = in_en ? (OUT_W'(1) << in_code) : '0;
    assign out_onehot = r_out_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != 2'd0);
        end
    end

`ifdef DEC_COUNT_EN
    logic [CNT_W-1:0] r_xfer_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (w_pop) begin
            r_xfer_count <= r_xfer_count + CNT_W'(1);
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_decoder_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_decoder_sync
// Description : Self-checking bench for onehot_decoder_sync against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_decoder_sync;

    localparam int SEL_W = 2;
    localparam int CNT_W = 2;
    localparam int OUT_W = 2**SEL_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
`ifdef DEC_COUNT_EN
    logic [CNT_W-1:0] xfer_count;
`endif

    int total_checks;
    int passed_checks;

    // Reference model: words in acceptance order and number of pops since reset
    logic [OUT_W-1:0] model_q[$];
    int               model_pops;

    onehot_decoder_sync #(
        .SEL_W(SEL_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_onehot(out_onehot)
`ifdef DEC_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare all outputs with the model, then clock one cycle with the given inputs.
    task automatic cycle(input logic v, input int code, input logic en, input logic rdy);
        logic             do_push;
        logic             do_pop;
        logic [OUT_W-1:0] exp_word;
        in_valid  = v;
        in_code   = SEL_W'(code);
        in_en     = en;
        out_ready = rdy;
        exp_word  = (model_q.size() != 0) ? model_q[0] : '0;
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("out_onehot", 32'(out_onehot), 32'(exp_word));
        check("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
        check("popcount", 32'($countones(out_onehot) <= 1), 32'd1);
`ifdef DEC_COUNT_EN
        check("xfer_count", 32'(xfer_count), 32'(model_pops % (1 << CNT_W)));
`endif
        do_push = v && (model_q.size() < 2);
        do_pop  = rdy && (model_q.size() > 0);
        @(posedge clk);
        if (do_pop) begin
            void'(model_q.pop_front());
            model_pops++;
        end
        if (do_push) model_q.push_back(en ? OUT_W'(1 << code) : '0);
        @(negedge clk);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        model_pops    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        in_en     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_onehot", 32'(out_onehot), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic decode with out_ready held high
        for (int i = 0; i < 4; i++) cycle(1'b1, i, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 0, 1'b0, 1'b1);

        // Enable low stores an all-zero word
        cycle(1'b1, 2, 1'b0, 1'b0);
        check("en_low_valid", 32'(out_valid), 32'd1);
        check("en_low_onehot", 32'(out_onehot), 32'd0);
        cycle(1'b0, 0, 1'b0, 1'b1);

        // Back-pressure: two pushes fill the FIFO, third offer refused
        cycle(1'b1, 3, 1'b1, 1'b0);
        cycle(1'b1, 1, 1'b1, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head", 32'(out_onehot), 32'h8);
        cycle(1'b1, 0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 0, 1'b0, 1'b0);
        // Full with simultaneous pop, then the re-offered code is accepted
        cycle(1'b1, 0, 1'b1, 1'b1);
        cycle(1'b1, 0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b1);

        // Asynchronous reset with two entries stored
        cycle(1'b1, 1, 1'b1, 1'b0);
        cycle(1'b1, 2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_onehot", 32'(out_onehot), 32'd0);
`ifdef DEC_COUNT_EN
        check("async_xfer_count", 32'(xfer_count), 32'd0);
`endif
        model_q.delete();
        model_pops = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Five transfers exercise the counter wrap when enabled
        for (int i = 0; i < 5; i++) cycle(1'b1, i % 4, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 0, 1'b0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, OUT_W - 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
`default_nettype wire
